// File: rtl/gpio.sv
// Memory-mapped 16-pin GPIO: two 8-bit ports, each with output-value, direction and pin-input view.
// Define GPIO_SYNC_EN to pass every pin input through a 2-flop synchronizer before it is read.
module gpio (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  reg_sel,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  inout  wire  [15:0] ports
);

  logic [7:0]  wr_a;
  logic [7:0]  dir_a;
  logic [7:0]  wr_b;
  logic [7:0]  dir_b;
  logic [15:0] pin_in;
  logic [7:0]  sel_byte;
  logic [15:0] drive_en;
  logic [15:0] drive_val;
  logic        unused_din;

  assign unused_din = ^din[31:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_a  <= 8'h00;
      dir_a <= 8'h00;
      wr_b  <= 8'h00;
      dir_b <= 8'h00;
    end else if (we) begin
      case (reg_sel)
        3'b000:  wr_a  <= din[7:0];
        3'b001:  dir_a <= din[7:0];
        3'b011:  wr_b  <= din[7:0];
        3'b100:  dir_b <= din[7:0];
        default: ;
      endcase
    end
  end

  assign drive_en  = {dir_b, dir_a};
  assign drive_val = {wr_b, wr_a};

  // Each pad is driven only while its direction bit is set; otherwise released to high-Z.
  for (genvar i = 0; i < 16; i++) begin : g_pad
    assign ports[i] = drive_en[i] ? drive_val[i] : 1'bz;
  end

`ifdef GPIO_SYNC_EN
  logic [15:0] sync_1;
  logic [15:0] sync_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 16'h0000;
      sync_2 <= 16'h0000;
    end else begin
      sync_1 <= ports;
      sync_2 <= sync_1;
    end
  end

  assign pin_in = sync_2;
`else
  assign pin_in = ports;
`endif

  always_comb begin
    sel_byte = 8'h00;
    case (reg_sel)
      3'b000:  sel_byte = wr_a;
      3'b001:  sel_byte = dir_a;
      3'b010:  sel_byte = pin_in[7:0];
      3'b011:  sel_byte = wr_b;
      3'b100:  sel_byte = dir_b;
      default: sel_byte = pin_in[15:8];
    endcase
  end

  assign dout = {4{sel_byte}};

endmodule

// File: tb/tb_gpio.sv
// Self-checking bench for gpio: directed test-plan sequences followed by randomized
// register writes and pad values, checked against an abstract register/pad model.
`timescale 1ns/100ps
module tb_gpio;

  logic        clk;
  logic        reset;
  logic [2:0]  reg_sel;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  wire  [15:0] ports;

  logic [15:0] tb_oe;
  logic [15:0] tb_val;

  logic [7:0]  m_wr [2];
  logic [7:0]  m_dir [2];

  int n_checks;
  int n_errors;

  gpio dut (
    .clk     (clk),
    .reset   (reset),
    .reg_sel (reg_sel),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .ports   (ports)
  );

  // Bench-side pad drivers: the bench drives only the pins the model says are inputs.
  for (genvar i = 0; i < 16; i++) begin : g_tb_pad
    assign ports[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_dir();
    return {m_dir[1], m_dir[0]};
  endfunction

  // Resolved pad value: outputs carry the written value, inputs carry what the bench drives.
  function automatic logic [15:0] model_pads();
    logic [15:0] d;
    d = model_dir();
    return (d & {m_wr[1], m_wr[0]}) | (~d & tb_val);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] s);
    logic [15:0] p;
    logic [7:0]  b;
    p = model_pads();
    case (s)
      3'd0:    b = m_wr[0];
      3'd1:    b = m_dir[0];
      3'd2:    b = p[7:0];
      3'd3:    b = m_wr[1];
      3'd4:    b = m_dir[1];
      default: b = p[15:8];
    endcase
    return {4{b}};
  endfunction

  task automatic model_clear();
    m_wr[0] = 8'h00; m_wr[1] = 8'h00;
    m_dir[0] = 8'h00; m_dir[1] = 8'h00;
  endtask

  task automatic do_write(input logic [2:0] s, input logic [31:0] d);
    logic [7:0] new_dir [2];
    new_dir[0] = m_dir[0];
    new_dir[1] = m_dir[1];
    if (s == 3'd1) new_dir[0] = d[7:0];
    if (s == 3'd4) new_dir[1] = d[7:0];
    reg_sel = s;
    din     = d;
    we      = 1'b1;
    // Release pins that are outputs before or after the edge so the bench never fights the DUT.
    tb_oe   = ~(model_dir() | {new_dir[1], new_dir[0]});
    @(posedge clk);
    #1;
    we = 1'b0;
    case (s)
      3'd0:    m_wr[0]  = d[7:0];
      3'd1:    m_dir[0] = d[7:0];
      3'd3:    m_wr[1]  = d[7:0];
      3'd4:    m_dir[1] = d[7:0];
      default: ;
    endcase
    tb_oe = ~model_dir();
  endtask

  // Enough edges for a synchronized pin view to catch up with the pads.
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int s = 0; s < 8; s++) begin
      reg_sel = s[2:0];
      #1;
      check($sformatf("%s_sel%0d", tag, s), dout, model_read(s[2:0]));
    end
  endtask

  logic [15:0] saved_ports;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    reg_sel  = 3'd0;
    we       = 1'b0;
    din      = 32'h0;
    tb_val   = 16'h0000;
    tb_oe    = 16'hFFFF;
    model_clear();

    repeat (3) @(posedge clk);
    #2;
    check("rst_sel0", dout, 32'h0);
    reg_sel = 3'd1; #1; check("rst_sel1", dout, 32'h0);
    reg_sel = 3'd3; #1; check("rst_sel3", dout, 32'h0);
    reg_sel = 3'd4; #1; check("rst_sel4", dout, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Input read with all pins inputs
    tb_val = 16'hFF00;
    settle();
    reg_sel = 3'd2; #1; check("in_a", dout, 32'h00000000);
    reg_sel = 3'd5; #1; check("in_b", dout, 32'hFFFFFFFF);

    // Port A output: WR first leaves the pads undriven by the DUT
    tb_val = 16'h0000;
    do_write(3'd0, 32'hFFFFFFFF);
    settle();
    check("wr_a_only_pad", {24'h0, ports[7:0]}, 32'h00);
    do_write(3'd1, 32'hFFFFFFFF);
    settle();
    check("dir_a_pad", {24'h0, ports[7:0]}, 32'hFF);
    reg_sel = 3'd2; #1; check("out_a_read", dout, 32'hFFFFFFFF);
    check_all("port_a");

    // Port B output; port A must not move
    do_write(3'd3, 32'hFFFFFFFF);
    do_write(3'd4, 32'hFFFFFFFF);
    settle();
    check("dir_b_pad", {24'h0, ports[15:8]}, 32'hFF);
    check("b_keeps_a", {24'h0, ports[7:0]}, 32'hFF);
    check_all("port_b");

    // Mixed direction on A
    do_write(3'd0, 32'h000000A5);
    do_write(3'd1, 32'h0000000F);
    tb_val[7:0] = 8'h30;
    settle();
    check("mixed_pad", {28'h0, ports[3:0]}, 32'h5);
    reg_sel = 3'd2; #1; check("mixed_read", dout, 32'h35353535);

    // Writes to read-only selects are ignored
    saved_ports = ports;
    do_write(3'd2, 32'h00000012);
    do_write(3'd7, 32'h00000012);
    settle();
    check("ro_ports", {16'h0, ports}, {16'h0, saved_ports});
    check_all("ro_wr");

    // Randomized writes and pad values
    for (int it = 0; it < 150; it++) begin
      tb_val = 16'($urandom);
      do_write(3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) do_write(3'($urandom_range(0, 7)), $urandom);
      settle();
      check_all($sformatf("rnd%0d", it));
    end

    // Async reset while outputs are driven: no clock edge allowed before the checks
    do_write(3'd0, 32'h0000005A);
    do_write(3'd1, 32'h000000FF);
    do_write(3'd3, 32'h000000C3);
    do_write(3'd4, 32'h000000FF);
    settle();
    @(negedge clk);
    reset  = 1'b0;
    tb_val = 16'h3CA5;
    tb_oe  = 16'hFFFF;
    model_clear();
    #1;
    check("arst_pads", {16'h0, ports}, 32'h00003CA5);
    reg_sel = 3'd0; #0.5; check("arst_sel0", dout, 32'h0);
    reg_sel = 3'd1; #0.5; check("arst_sel1", dout, 32'h0);
    reg_sel = 3'd3; #0.5; check("arst_sel3", dout, 32'h0);
    reg_sel = 3'd4; #0.5; check("arst_sel4", dout, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    settle();
    check_all("post_arst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gpio.md
# gpio

Memory-mapped 16-pin general-purpose I/O block (`module_gpio`) on the CPU peripheral bus. It has two 8-bit ports: A on `ports[7:0]` and B on `ports[15:8]`. Each port has an output-value register, a direction register and a read-only pin-input view, selected by a 3-bit register select. Writes take the low byte of the bus data. Reads return the selected byte replicated on all four byte lanes.

## Interface
- No parameters.
- `clk`  in  1  system clock; all register updates on its rising edge.
- `reset`  in  1  reset; one clock; reset is asynchronous and active-low.
- `reg_sel`  in  3  register select (see Operation).
- `we`  in  1  write enable, sampled on rising `clk`.
- `din`  in  32  write data; only `din[7:0]` is used.
- `dout`  out  32  read data; combinational from `reg_sel`.
- `ports`  inout  16  pads; `[7:0]` = port A, `[15:8]` = port B.

## Operation
- Internal registers, all 8 bit: `GPIOWR_A`, `GPIODIR_A`, `GPIOWR_B`, `GPIODIR_B`.
- `reg_sel` map:
  - 000 = `GPIOWR_A` (R/W)
  - 001 = `GPIODIR_A` (R/W)
  - 010 = port A pins (RO)
  - 011 = `GPIOWR_B` (R/W)
  - 100 = `GPIODIR_B` (R/W)
  - 101, 110, 111 = port B pins (RO, aliases)
- Write: when `we`=1 at rising `clk` and `reg_sel` addresses an R/W register, that register loads `din[7:0]`.
  - Writes to RO selects are ignored; no register changes.
- Read: `dout` = {4{sel_byte}}, where sel_byte is:
  - the addressed register, or
  - `ports[7:0]` for 010, or
  - `ports[15:8]` for 101–111.
- Pad drive, per bit i of each port:
  - DIR[i]=1: pad driven with WR[i].
  - DIR[i]=0: pad is high-Z (input).
- Pin reads return the resolved pad value, so output pins read back their driven value.
- `dout` has no X/Z: undriven input pins read whatever value the pad resolves to.

## Timing
- `reset` low asynchronously clears all four registers to 0x00.
  - All pads become high-Z (inputs) immediately.
  - `dout` for any register select = 0x00000000.
- Reset has priority over `we`. Registers hold while `reset` is high and `we`=0.
- Write latency: register and pad drive update on the same rising edge that samples `we`=1.
  - Register readback on `dout` is valid after that edge, combinationally.
- Register and pin reads are combinational, zero cycles, when `GPIO_SYNC_EN` is undefined.
- Writing WR and DIR in consecutive cycles is legal.
  - Pads drive WR as of the edge on which DIR becomes 1.
- Reset asserted mid-sequence discards partially configured state, with no glitch beyond the return to high-Z.

## Configuration
- Macro `GPIO_SYNC_EN`.
- Defined: each of the 16 pin inputs passes through a 2-flop synchronizer clocked by `clk`.
  - Pin reads reflect the pad value from 2 rising edges earlier.
  - Synchronizer flops reset to 0 asynchronously.
  - Register reads stay combinational.
- Undefined: pin reads are purely combinational from the pads.

## Test plan
- Reset: pulse `reset` low, release.
  - Read selects 000, 001, 011, 100 -> `dout`=0x00000000 each.
  - `ports` all Z.
- Input read, with bench driving `ports`=0xFF00 and all DIR=0:
  - `reg_sel`=010 -> `dout`=0x00000000 (`dout[23:16]`=0x00).
  - `reg_sel`=101 -> `dout`=0xFFFFFFFF (`dout[15:8]`=0xFF).
  - With `GPIO_SYNC_EN`, the same values appear 2 cycles later.
- Port A output, bench releases pads to Z:
  - Write `din`=0xFFFFFFFF to 000 -> `GPIOWR_A`=0xFF, `ports[7:0]` still Z.
  - Then write to 001 -> `GPIODIR_A`=0xFF, `ports[7:0]`=0xFF.
  - Read 010 -> `dout`=0xFFFFFFFF.
- Port B output: same sequence via selects 011 then 100.
  - `ports[15:8]`=0xFF; port A is unaffected.
- Mixed direction, A:
  - WR=0xA5, DIR=0x0F, bench drives `ports[7:4]`=0x3.
  - `ports[3:0]`=0x5; read 010 -> `dout`=0x35353535.
- Ignored writes: `we`=1 with `reg_sel`=010 or 111, `din`=0x12.
  - No register changes; `ports` unchanged.
- Async reset while outputs are driven: all registers 0x00 and pads Z without waiting for a clock edge.
